// File: rtl/puf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// puf_ctrl_pkg
//   Shared definitions for the arbiter-PUF evaluation sequencer:
//     state_t    - sequencer FSM state encoding (also exported for debug)
//     LFSR_TAPS  - Galois feedback mask of the 8-bit challenge LFSR
//     lfsr_next  - one right-shift Galois step of the challenge LFSR
// ---------------------------------------------------------------------------
package puf_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ARM    = 3'd2,
    FIRE   = 3'd3,
    SAMPLE = 3'd4,
    NEXT   = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Right shift; when the bit shifted out is 1 the taps are folded back in.
  // A non-zero state never maps to zero, giving the maximal 255-state cycle.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/puf_lfsr8.sv
// ---------------------------------------------------------------------------
// puf_lfsr8
//   8-bit Galois LFSR holding the current PUF challenge.
//   Ports:
//     clk, rst    clock and synchronous active-high reset (clears to 0)
//     load_i      load load_val_i (has priority over step_i)
//     load_val_i  value to load; the caller guarantees it is non-zero
//     step_i      advance one Galois step
//     out_o       current LFSR state
// ---------------------------------------------------------------------------
module puf_lfsr8
  import puf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       step_i,
  output logic [7:0] out_o
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'h00;
    end else if (load_i) begin
      lfsr_q <= load_val_i;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign out_o = lfsr_q;

endmodule

// File: rtl/puf_eval_sequencer.sv
// ---------------------------------------------------------------------------
// puf_eval_sequencer
//   Drives an 8-stage arbiter PUF: challenges come from a seeded LFSR, each
//   challenge is raced VOTES times (ARM = discharge, FIRE = launch, SAMPLE =
//   read synchronised arbiter output), and the majority result of each
//   challenge is packed LSB-first into an NUM_RESP-bit response word.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start, seed     run request (accepted only in IDLE) and LFSR seed
//     busy            high from LOAD until the word is ready
//     puf_challenge   challenge to the PUF (stable through ARM/FIRE/SAMPLE)
//     puf_pulse       registered race-launch pulse, high during FIRE
//     puf_response    asynchronous arbiter output, used only after a 2-flop sync
//     resp_word       voted response word
//     resp_valid      response word available
//     resp_ready      consumer accept
//     dbg_state       current FSM state
// ---------------------------------------------------------------------------
module puf_eval_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int CHAL_W   = 8,
  parameter int NUM_RESP = 8,
  parameter int VOTES    = 5,
  parameter int SETTLE   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CHAL_W-1:0]   seed,
  output logic                busy,
  output logic [CHAL_W-1:0]   puf_challenge,
  output logic                puf_pulse,
  input  logic                puf_response,
  output logic [NUM_RESP-1:0] resp_word,
  output logic                resp_valid,
  input  logic                resp_ready,
  output state_t              dbg_state
);

  localparam int VW = $clog2(VOTES + 1);
  localparam int IW = $clog2(NUM_RESP);
  localparam int TW = $clog2(SETTLE);

  localparam logic [TW-1:0] TIMER_INIT = TW'(SETTLE - 1);
  localparam logic [VW-1:0] LAST_EVAL  = VW'(VOTES - 1);
  localparam logic [VW-1:0] HALF_VOTES = VW'(VOTES / 2);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_RESP - 1);

  state_t                state_q;
  logic [CHAL_W-1:0]     seed_q;
  logic [TW-1:0]         timer_q;
  logic [VW-1:0]         ones_q;
  logic [VW-1:0]         eval_q;
  logic [IW-1:0]         idx_q;
  logic [1:0]            sync_q;
  logic                  busy_q;
  logic                  pulse_q;
  logic [NUM_RESP-1:0]   resp_word_q;
  logic                  resp_valid_q;
  logic [7:0]            lfsr_out;

  // The LFSR register is the challenge register: it is loaded in LOAD and
  // stepped in NEXT, so the challenge cannot move during ARM/FIRE/SAMPLE.
  puf_lfsr8 u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == LOAD),
    .load_val_i (seed_q),
    .step_i     (state_q == NEXT),
    .out_o      (lfsr_out)
  );

  // Output handshake: resp_valid rises on entry to DONE and, together with
  // resp_word, holds until a clock edge sees resp_valid && resp_ready; that
  // edge is the transfer, after which the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      seed_q       <= '0;
      timer_q      <= '0;
      ones_q       <= '0;
      eval_q       <= '0;
      idx_q        <= '0;
      sync_q       <= '0;
      busy_q       <= 1'b0;
      pulse_q      <= 1'b0;
      resp_word_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], puf_response};
      case (state_q)
        IDLE: begin
          if (start) begin
            // An all-zero seed would lock the LFSR at zero.
            seed_q  <= (seed == '0) ? CHAL_W'(1) : seed;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          resp_word_q <= '0;
          ones_q      <= '0;
          eval_q      <= '0;
          idx_q       <= '0;
          timer_q     <= TIMER_INIT;
          state_q     <= ARM;
        end
        ARM: begin
          if (timer_q == '0) begin
            timer_q <= TIMER_INIT;
            pulse_q <= 1'b1;
            state_q <= FIRE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        FIRE: begin
          if (timer_q == '0) begin
            pulse_q <= 1'b0;
            state_q <= SAMPLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        SAMPLE: begin
          ones_q <= ones_q + VW'(sync_q[1]);
          eval_q <= eval_q + 1'b1;
          if (eval_q == LAST_EVAL) begin
            state_q <= NEXT;
          end else begin
            timer_q <= TIMER_INIT;
            state_q <= ARM;
          end
        end
        NEXT: begin
          resp_word_q[idx_q] <= (ones_q > HALF_VOTES);
          ones_q <= '0;
          eval_q <= '0;
          if (idx_q == LAST_IDX) begin
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            timer_q <= TIMER_INIT;
            state_q <= ARM;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign puf_challenge = CHAL_W'(lfsr_out);
  assign puf_pulse     = pulse_q;
  assign resp_word     = resp_word_q;
  assign resp_valid    = resp_valid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
module tb_puf_eval_sequencer;
  import puf_ctrl_pkg::*;

  localparam int NUM_RESP = 8;
  localparam int VOTES    = 5;
  localparam int SETTLE   = 4;
  localparam int LATENCY  = 1 + NUM_RESP * (VOTES * (2 * SETTLE + 1) + 1);
  localparam logic [7:0] CHAL_TAB [8] = '{8'h01, 8'hB8, 8'h5C, 8'h2E,
                                          8'h17, 8'hB3, 8'hE1, 8'hC8};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       busy;
  logic [7:0] puf_challenge;
  logic       puf_pulse;
  logic       puf_response;
  logic [7:0] resp_word;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  state_t     dbg_state;

  puf_eval_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .seed          (seed),
    .busy          (busy),
    .puf_challenge (puf_challenge),
    .puf_pulse     (puf_pulse),
    .puf_response  (puf_response),
    .resp_word     (resp_word),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .dbg_state     (dbg_state)
  );

  // ---------------- PUF model ----------------
  // mode 0: parity of challenge; mode 1: 1 on votes 1-2; mode 2: 1 on votes 3-5
  int resp_mode = 0;
  int pulse_cnt = 0;
  int base      = 0;
  int vote_idx;
  logic [7:0] chal_log[$];

  always @(posedge puf_pulse) begin
    pulse_cnt = pulse_cnt + 1;
    chal_log.push_back(puf_challenge);
  end

  always_comb begin
    vote_idx = ((pulse_cnt - base - 1) % VOTES) + 1;
    case (resp_mode)
      0:       puf_response = ^puf_challenge;
      1:       puf_response = (vote_idx <= 2);
      default: puf_response = (vote_idx >= 3);
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [7:0] s);
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    base  = pulse_cnt;
    @(negedge clk);
    start = 1'b0;
    seed  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic collect(input string tag);
    logic [7:0] e;
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    e = exp_q.pop_front();
    check({tag, "_word"}, 32'(resp_word), 32'(e));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic full_run(input string tag, input logic [7:0] s, input int mode,
                          input logic [7:0] exp_word);
    int cyc;
    resp_mode = mode;
    exp_q.push_back(exp_word);
    do_start(s);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(LATENCY));
    collect(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    // 1: reset held 3 cycles with start asserted
    rst   = 1'b1;
    start = 1'b1;
    seed  = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pulse", 32'(puf_pulse), 32'd0);
      check("rst_chal", 32'(puf_challenge), 32'd0);
      check("rst_word", 32'(resp_word), 32'd0);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));

    // 2: parity response, seed 01
    full_run("parity", 8'h01, 0, 8'hA1);
    for (int i = 0; i < 8; i++)
      check($sformatf("chal%0d", i), 32'(chal_log[base + i * VOTES]), 32'(CHAL_TAB[i]));
    for (int i = 0; i < 8 * VOTES; i++)
      check($sformatf("chal_stable%0d", i), 32'(chal_log[base + i]), 32'(CHAL_TAB[i / VOTES]));

    // 3: vote patterns
    full_run("vote_lo", 8'($urandom_range(1, 255)), 1, 8'h00);
    full_run("vote_hi", 8'($urandom_range(1, 255)), 2, 8'hFF);

    // 4: zero seed maps to 01
    full_run("seed0", 8'h00, 0, 8'hA1);
    check("seed0_first_chal", 32'(chal_log[base]), 32'h01);

    // 5: back-pressure in DONE, starts ignored
    resp_mode = 0;
    exp_q.push_back(8'hA1);
    do_start(8'h01);
    wait_valid(cyc);
    check("bp_latency", 32'(cyc), 32'(LATENCY));
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom_range(0, 1));
      seed  = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("bp_valid_hold", 32'(resp_valid), 32'd1);
      check("bp_word_hold", 32'(resp_word), 32'hA1);
      check("bp_state", 32'(dbg_state), 32'(DONE));
    end
    start = 1'b1;  // coincides with the transfer edge and must be ignored
    collect("bp");
    start = 1'b0;
    @(negedge clk);
    check("bp_start_ignored", 32'(dbg_state), 32'(IDLE));

    // 6: reset during FIRE of bit 3, then a clean run
    resp_mode = 0;
    do_start(8'h01);
    cyc = 0;
    while (pulse_cnt < base + 3 * VOTES + 1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reach_fire", 32'(cyc < 2000), 32'd1);
    check("abort_in_fire", 32'(dbg_state), 32'(FIRE));
    check("abort_pulse_hi", 32'(puf_pulse), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pulse", 32'(puf_pulse), 32'd0);
    check("abort_word", 32'(resp_word), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(resp_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    full_run("after_abort", 8'h01, 0, 8'hA1);

    // ---------------- final report ----------------
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
